neuron_mac: RTL and testbench
=============================

# neuron_mac

Serial multiply-accumulate front end of the simple neuron. Accepts a stream of signed Q5.6 (input, weight) pairs over a valid/ready handshake and forms the product of each pair. Accumulates the products at full width. At the end of a vector it emits one saturated Q5.6 weighted sum, plus status. That sum drives the `a` operand of the downstream Q5.6 bias adder.

## Interface
- `DATA_W`, 12: operand and result width, signed Q5.6 (6 fractional bits).
- `FRAC`, 6: fractional bits; the product is shifted right by this amount.
- `MAX_N`, 64: maximum beats per vector.
- `ACC_W`, 24: accumulator width. It must be ≥ (2·DATA_W − FRAC) + clog2(MAX_N).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  pair valid.
- `s_ready`  out  1  block can accept a pair.
- `s_x`  in  DATA_W  signed input sample, Q5.6.
- `s_w`  in  DATA_W  signed weight, Q5.6.
- `s_last`  in  1  final pair of the vector.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  DATA_W  saturated weighted sum, Q5.6.
- `m_sat`  out  1  `m_data` was clipped.
- `m_err`  out  1  vector was terminated at `MAX_N` without `s_last`.
- `m_count`  out  clog2(MAX_N+1)  number of beats in the vector.

## Operation
- States: `RUN` (reset state) and `HOLD`.
- **RUN:**
  - `s_ready=1`, `m_valid=0`.
  - Beat accepted when `s_valid & s_ready`.
  - Product: `p = s_x*s_w`, 2·DATA_W bits, Q11.12.
  - Scaled product: `q = p >>> FRAC`, arithmetic shift, Q11.6, sign-extended to ACC_W.
  - On an accepted beat, `next = acc + q` and `cnt+1`.
- **End of vector:** occurs on an accepted beat with `s_last=1`, or on the beat where `cnt+1 == MAX_N`. On that beat:
  - `m_data` = `next` clipped to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−2048, 2047].
  - `m_sat = 1` if clipping occurred.
  - `m_err = 1` if `s_last` was 0.
  - `m_count = cnt+1`.
  - `acc` and `cnt` clear to 0.
  - State goes to `HOLD`.
- **HOLD:**
  - `s_ready=0`, `m_valid=1`.
  - Outputs are stable until `m_ready=1`.
  - On `m_ready=1` the state returns to `RUN`.
- The accumulator never wraps within `MAX_N` beats for the given ACC_W. Only the final result saturates.
- Reset values:
  - state `RUN`
  - `acc=0`, `cnt=0`
  - `m_valid=0`, `m_data=0`, `m_sat=0`, `m_err=0`, `m_count=0`
  - `s_ready=1` once reset is released.
- Reset asserted mid-vector discards the partial sum. Reset asserted in `HOLD` drops the pending result.

## Timing
- Accept rate: one beat per cycle in `RUN`.
- Latency: result registered. `m_valid` rises the cycle after the end-of-vector beat is accepted.
- No bypass: in the cycle `HOLD` completes (`m_ready=1`), `s_ready` is still 0. The next vector's first beat can be accepted one cycle later. Back-to-back vector throughput is N+1 cycles.
- `m_valid` must not drop without `m_ready`. `m_data`, `m_sat`, `m_err` and `m_count` must not change while `m_valid & !m_ready`.
- `s_x`, `s_w` and `s_last` are sampled only on an accepted beat. `s_valid` in `HOLD` is ignored.
- A single-beat vector (`s_last` on the first beat) is legal: `m_count=1`.

## Configuration
- `NEURON_MAC_ROUND_EN` defined: `q = (p + 2^(FRAC−1)) >>> FRAC`, i.e. round half toward +∞.
- Not defined: `q = p >>> FRAC`, i.e. truncate toward −∞.
- The macro affects only the product scaling. Accumulation and saturation are identical in both builds.

## Structure
- Shared package `nn_fixed_pkg` holds:
  - constants `Q_INT=5`, `Q_FRAC=6`, `Q_W=12`;
  - saturation limits `Q_MAX=2047`, `Q_MIN=-2048`;
  - state enum `mac_state_t {RUN, HOLD}`.
- One sub-module, `q_saturate`: combinational ACC_W→DATA_W clip with overflow flag. The same module is reusable for the adder output.

## Test plan
- (3.25→208, 1.75→112), `s_last` → `m_data=364` (5.6875), `m_sat=0`, `m_err=0`, `m_count=1`.
- (1.0, 2.0), then (0.5, −1.0) with `s_last` → `m_data=96` (1.5), `m_count=2`, `m_valid` one cycle after the second beat.
- (2047, 2047), `s_last` → `m_data=2047`, `m_sat=1`. (−2048, 2047), `s_last` → `m_data=−2048`, `m_sat=1`.
- (1, 32), `s_last`: truncate build → `m_data=0`; `ROUND_EN` build → 1. (−1, 32): truncate build → −1; `ROUND_EN` build → 0.
- 64 beats of (64, 64) with no `s_last` → `m_err=1`, `m_count=64`, `m_data=2047`, `m_sat=1`.
- Hold `m_ready=0` for 5 cycles → `m_data` stable and `s_ready=0`. Assert `rst` mid-vector after 3 beats → all outputs 0, next vector (64, 64), `s_last` → `m_data=64`.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared Q5.6 fixed-point constants and the MAC handshake state type.
package nn_fixed_pkg;

  localparam int Q_INT  = 5;
  localparam int Q_FRAC = 6;
  localparam int Q_W    = 12;

  localparam int Q_MAX = 2047;
  localparam int Q_MIN = -2048;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } mac_state_t;

endpackage

// File: rtl/neuron_mac_q_saturate.sv
// Combinational clip of a wide signed value into a narrow signed range with overflow flag.
module q_saturate #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // clip to the representable output range
  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
      ovf  = 1'b1;
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
      ovf  = 1'b1;
    end else begin
      dout = din[OUT_W-1:0];
      ovf  = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Serial Q5.6 multiply-accumulate with saturated per-vector result.
// Define NEURON_MAC_ROUND_EN to round products half toward +inf instead of truncating.
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int FRAC   = 6,
  parameter int MAX_N  = 64,
  parameter int ACC_W  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_W-1:0]     s_x,
  input  logic signed [DATA_W-1:0]     s_w,
  input  logic                         s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_W-1:0]     m_data,
  output logic                         m_sat,
  output logic                         m_err,
  output logic [$clog2(MAX_N+1)-1:0]   m_count
);

  localparam int CNT_W = $clog2(MAX_N+1);
  localparam int P_W   = 2*DATA_W;

  mac_state_t               state_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]         cnt_r;

  logic signed [P_W-1:0]    p_s;
  logic signed [P_W-1:0]    q_s;
  logic signed [ACC_W-1:0]  next_s;
  logic [CNT_W-1:0]         cnt_inc_s;
  logic                     eov_s;
  logic signed [DATA_W-1:0] sat_data_s;
  logic                     sat_ovf_s;

  assign p_s = s_x * s_w;

`ifdef NEURON_MAC_ROUND_EN
  localparam logic signed [P_W-1:0] HALF = {{(P_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  assign q_s = (p_s + HALF) >>> FRAC;
`else
  assign q_s = p_s >>> FRAC;
`endif

  assign next_s    = acc_r + ACC_W'(q_s);
  assign cnt_inc_s = cnt_r + CNT_W'(1);
  // a vector also ends when it reaches MAX_N beats without s_last
  assign eov_s     = s_last | (cnt_inc_s == CNT_W'(MAX_N));

  q_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat (
    .din  (next_s),
    .dout (sat_data_s),
    .ovf  (sat_ovf_s)
  );

  // handshake FSM, accumulator and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      acc_r   <= '0;
      cnt_r   <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= 1'b0;
      m_err   <= 1'b0;
      m_count <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (s_valid) begin
            if (eov_s) begin
              m_data  <= sat_data_s;
              m_sat   <= sat_ovf_s;
              m_err   <= ~s_last;
              m_count <= cnt_inc_s;
              m_valid <= 1'b1;
              s_ready <= 1'b0;
              acc_r   <= '0;
              cnt_r   <= '0;
              state_r <= HOLD;
            end else begin
              acc_r <= next_s;
              cnt_r <= cnt_inc_s;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed vectors, monitor pops on output handshake.
module tb_neuron_mac;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [11:0] s_x = '0;
  logic signed [11:0] s_w = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic signed [11:0] m_data;
  logic              m_sat;
  logic              m_err;
  logic [6:0]        m_count;

  typedef struct {
    int d;
    int sat;
    int err;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  neuron_mac dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .s_w     (s_w),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_sat   (m_sat),
    .m_err   (m_err),
    .m_count (m_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic expect_res(input int d, input int sat, input int err, input int cnt);
    exp_t e;
    e.d = d; e.sat = sat; e.err = err; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // drive one pair; returns #1 after the accepting edge
  task automatic beat(input int x, input int w, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_x = 12'(x);
    s_w = 12'(w);
    s_last = last;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // monitor: compare each handshaken result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_data", int'(m_data), e.d);
        chk("m_sat", int'(m_sat), e.sat);
        chk("m_err", int'(m_err), e.err);
        chk("m_count", int'(m_count), e.cnt);
      end
    end
  end

  initial begin
    #2;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_count", int'(m_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", int'(s_ready), 1);

    // 3.25 * 1.75
    expect_res(364, 0, 0, 1);
    beat(208, 112, 1'b1);
    drain();

    // 1.0*2.0 + 0.5*-1.0, with latency check
    expect_res(96, 0, 0, 2);
    beat(64, 128, 1'b0);
    chk("no_valid_mid", int'(m_valid), 0);
    beat(32, -64, 1'b1);
    chk("valid_latency", int'(m_valid), 1);
    drain();

    // saturation both ways
    expect_res(2047, 1, 0, 1);
    beat(2047, 2047, 1'b1);
    drain();
    expect_res(-2048, 1, 0, 1);
    beat(-2048, 2047, 1'b1);
    drain();

    // product scaling
`ifdef NEURON_MAC_ROUND_EN
    expect_res(1, 0, 0, 1);
    beat(1, 32, 1'b1);
    expect_res(0, 0, 0, 1);
    beat(-1, 32, 1'b1);
`else
    expect_res(0, 0, 0, 1);
    beat(1, 32, 1'b1);
    expect_res(-1, 0, 0, 1);
    beat(-1, 32, 1'b1);
`endif
    drain();

    // MAX_N termination without s_last
    expect_res(2047, 1, 1, 64);
    for (int i = 0; i < 64; i++) beat(64, 64, 1'b0);
    drain();

    // backpressure: outputs hold, s_valid ignored in HOLD
    m_ready = 1'b0;
    expect_res(64, 0, 0, 1);
    beat(64, 64, 1'b1);
    s_valid = 1'b1; s_x = 12'sd100; s_w = 12'sd100; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(m_valid), 1);
      chk("hold_data", int'(m_data), 64);
      chk("hold_s_ready", int'(s_ready), 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b0; s_last = 1'b0;
    chk("release_s_ready", int'(s_ready), 0);
    drain();
    chk("no_ghost_vector", int'(m_valid), 0);

    // reset mid-vector drops partial sum
    for (int i = 0; i < 3; i++) beat(64, 64, 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_data", int'(m_data), 0);
    chk("mid_rst_sat", int'(m_sat), 0);
    chk("mid_rst_err", int'(m_err), 0);
    chk("mid_rst_count", int'(m_count), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    expect_res(64, 0, 0, 1);
    beat(64, 64, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
